// File: rtl/checkout_item_monitor_if.sv
// ---------------------------------------------------------------------------
// checkout_item_monitor_if
//   Scan handshake bundle between the input conditioning (master) and the
//   checkout item monitor (slave).
//   item_valid : scan strobe, honoured only while item_ready=1
//   item_code  : scanned item code, CODE_W bits
//   item_paid  : item marked paid/discounted, suppresses the theft alarm
//   item_ready : slave can accept a scan this cycle
// ---------------------------------------------------------------------------
interface checkout_item_monitor_if #(
  parameter int CODE_W = 3
);
  logic              item_valid;
  logic [CODE_W-1:0] item_code;
  logic              item_paid;
  logic              item_ready;

  modport master (
    output item_valid,
    output item_code,
    output item_paid,
    input  item_ready
  );

  modport slave (
    input  item_valid,
    input  item_code,
    input  item_paid,
    output item_ready
  );
endinterface

// File: rtl/checkout_item_monitor.sv
// ---------------------------------------------------------------------------
// checkout_item_monitor
//   Classifies strobed item scans through per-code sale/theft lookup masks,
//   drives a registered sale light and a timed, operator-clearable theft
//   alarm, and keeps saturating scan and theft counters.
//
//   Ports:
//     i_clk          : system clock, rising edge
//     i_reset_n      : synchronous active-low reset
//     scan (slave)   : item_valid/item_code/item_paid in, item_ready out
//     i_clear_alarm  : operator clear, only acts while the alarm is running
//     o_sale_led     : sale light for the last evaluated item
//     o_stolen_led   : theft alarm light
//     o_item_count   : saturating count of evaluated items
//     o_theft_count  : saturating count of alarms raised
//
//   Flow: IDLE captures a scan, EVAL classifies it in exactly one cycle,
//   ALARM holds the stolen light for ALARM_CYCLES cycles or until cleared.
//   Every output is a register or a decode of the state register, so there
//   is no combinational path from inputs to outputs.
// ---------------------------------------------------------------------------
module checkout_item_monitor #(
  parameter int                     CODE_W       = 3,
  parameter logic [2**CODE_W-1:0]   SALE_MASK    = 8'hEC,
  parameter logic [2**CODE_W-1:0]   THEFT_MASK   = 8'h31,
  parameter int                     ALARM_CYCLES = 8,
  parameter int                     CNT_W        = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  checkout_item_monitor_if.slave        scan,
  input  logic                          i_clear_alarm,
  output logic                          o_sale_led,
  output logic                          o_stolen_led,
  output logic [CNT_W-1:0]              o_item_count,
  output logic [CNT_W-1:0]              o_theft_count
);

  // Timer only needs to hold ALARM_CYCLES-1; keep at least one bit.
  localparam int TMR_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ALARM_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_ALARM = 2'd2;

  // Captured scan, held from IDLE into EVAL.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              paid;
  } item_t;

  logic [1:0]       r_state;
  item_t            r_item;
  logic [TMR_W-1:0] r_timer;
  logic             r_sale_led;
  logic             r_stolen_led;
  logic [CNT_W-1:0] r_item_count;
  logic [CNT_W-1:0] r_theft_count;

  logic             w_is_sale;
  logic             w_is_theft;
  logic             w_alarm_exit;

  assign w_is_sale    = SALE_MASK[r_item.code];
  assign w_is_theft   = THEFT_MASK[r_item.code] & ~r_item.paid;
  // Clear and timeout collapse into one exit; nothing is done twice.
  assign w_alarm_exit = i_clear_alarm | (r_timer == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_item        <= '0;
      r_timer       <= '0;
      r_sale_led    <= 1'b0;
      r_stolen_led  <= 1'b0;
      r_item_count  <= '0;
      r_theft_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan.item_valid) begin
            r_item.code <= scan.item_code;
            r_item.paid <= scan.item_paid;
            r_state     <= S_EVAL;
          end
        end

        S_EVAL: begin
          r_sale_led <= w_is_sale;
          if (r_item_count != '1)
            r_item_count <= r_item_count + CNT_W'(1);
          if (w_is_theft) begin
            r_stolen_led <= 1'b1;
            r_timer      <= TMR_LOAD;
            if (r_theft_count != '1)
              r_theft_count <= r_theft_count + CNT_W'(1);
            r_state <= S_ALARM;
          end else begin
            r_stolen_led <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        S_ALARM: begin
          // Timer loads with ALARM_CYCLES-1 and exits on the edge after it
          // reaches zero, giving exactly ALARM_CYCLES cycles of light.
          if (w_alarm_exit) begin
            r_stolen_led <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end

        default: begin
          r_stolen_led <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign scan.item_ready = (r_state == S_IDLE);
  assign o_sale_led      = r_sale_led;
  assign o_stolen_led    = r_stolen_led;
  assign o_item_count    = r_item_count;
  assign o_theft_count   = r_theft_count;

endmodule

// File: doc/checkout_item_monitor.md
Name: checkout_item_monitor

Overview:
- Sequential, parametrised successor to the combinational store sale/stolen light logic.
- Accepts item scans as strobed transactions: item code plus a paid/marked flag.
- Classifies each item through per-code lookup masks and drives a registered sale light.
- Drives a timed theft alarm, clearable by the operator, and keeps saturating scan and theft counters.
- Sits between the switch/scan input conditioning and the LED/HEX display drivers.

Parameters:
- CODE_W, 3: item code width; 2**CODE_W distinct codes.
- SALE_MASK, 8'hEC (width 2**CODE_W): bit k=1 means code k is on sale. Default reproduces legacy codes 2,3,5,6,7.
- THEFT_MASK, 8'h31 (width 2**CODE_W): bit k=1 means code k is high-value and alarms when unpaid. Default reproduces legacy codes 0,4,5.
- ALARM_CYCLES, 8: cycles the stolen light stays asserted; must be >=1.
- CNT_W, 8: width of item_count and theft_count.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- item_valid, input, 1: scan strobe; sampled only when item_ready=1.
- item_code, input, CODE_W: code of the scanned item.
- item_paid, input, 1: item marked paid/discounted; suppresses the theft alarm.
- clear_alarm, input, 1: operator clear; ends the alarm early.
- item_ready, output, 1: block can accept a scan (state IDLE).
- sale_led, output, 1: sale light for the last evaluated item.
- stolen_led, output, 1: theft alarm light.
- item_count, output, CNT_W: saturating count of evaluated items.
- theft_count, output, CNT_W: saturating count of alarms raised.

Behaviour:
- Reset, when reset_n=0 at a clk edge:
  - state=IDLE.
  - sale_led=0, stolen_led=0, item_count=0, theft_count=0, alarm timer=0.
  - Captured code/paid registers=0.
  - item_ready=1 after the edge.
  - Reset overrides all other inputs, including during EVAL or ALARM.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- FSM, IDLE:
  - item_ready=1.
  - If item_valid=1: capture item_code and item_paid, then go to EVAL.
  - Otherwise stay in IDLE. Outputs hold.
- FSM, EVAL (exactly one cycle, item_ready=0):
  - sale_led <= SALE_MASK[code_q].
  - item_count <= item_count+1, saturating at all-ones.
  - If THEFT_MASK[code_q] & ~paid_q:
    - stolen_led <= 1.
    - theft_count <= theft_count+1, saturating.
    - timer <= ALARM_CYCLES-1.
    - Go to ALARM.
  - Otherwise stolen_led <= 0 and go to IDLE.
- FSM, ALARM (item_ready=0, stolen_led=1):
  - Each cycle: if clear_alarm=1 or timer==0, then stolen_led <= 0 and go to IDLE.
  - Otherwise timer <= timer-1.
  - A clear_alarm arriving in the same cycle as timer==0 gives the same single exit; no double action.
- Alarm duration: with no clear, stolen_led is high for exactly ALARM_CYCLES cycles.
- Latency: item_valid sampled at edge E0 -> sale_led, stolen_led and counters update at edge E1. item_ready is high again after E1 (no theft) or after the alarm exits.
- Input acceptance:
  - item_valid while item_ready=0 is ignored (dropped, not queued).
  - The upstream side must hold or resend the scan.
  - clear_alarm outside ALARM has no effect.
- sale_led holds its value until the next EVAL; it is not cleared by alarm exit.
- Back-to-back scans: item_valid held high in IDLE gives one accepted item every 2 cycles (IDLE, EVAL, IDLE, ...).
- Counters saturate: at all-ones an increment leaves the value unchanged; there is no wrap.
- Masks are indexed by code_q directly. All 2**CODE_W codes are legal.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 cycles, release -> all outputs 0, item_ready=1, and they stay so for 10 idle cycles.
- Sale item: code=3, paid=0, valid pulse -> next edge sale_led=1, stolen_led=0, item_count=1, item_ready=1. Then code=1, paid=0 -> sale_led=0, stolen_led=0, item_count=2.
- Theft timeout: code=4, paid=0 -> sale_led=0, stolen_led=1 for exactly 8 cycles, theft_count=1, item_ready=0 throughout. A scan issued mid-alarm (code=2) is dropped: item_count stays 1.
- Paid high-value: code=0, paid=1 -> stolen_led=0, theft_count=0. Also code=5, paid=0 -> sale_led=1 and stolen_led=1 together.
- Early clear: code=0, paid=0, then clear_alarm on the 3rd alarm cycle -> stolen_led=0 on the next edge and item_ready=1. Repeat with clear_alarm coinciding with timer==0 -> single exit, theft_count incremented once.
- Saturation and reset mid-alarm: run with CNT_W=2 and 5 scans -> item_count sticks at 3. Assert reset_n=0 during ALARM -> stolen_led=0, counters=0, state IDLE on that edge.
